// File: rtl/cbd_pkg.sv
// Shared constants and types for the cascadable borrow-chain down counter.
package cbd_pkg;

    localparam int CBD_WIDTH_DEFAULT = 8;
    localparam int CBD_WIDTH_MIN     = 2;
    localparam int CBD_WIDTH_MAX     = 16;

    // Counter word sized for the widest legal build; narrower builds use the low bits.
    typedef logic [CBD_WIDTH_MAX-1:0] cbd_word_t;

    function automatic cbd_word_t cbd_ones(input int width);
        cbd_word_t result;
        result = '0;
        for (int i = 0; i < CBD_WIDTH_MAX; i++) begin
            if (i < width) begin
                result[i] = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/cbd_borrow_cell.sv
// One bit of a ripple borrow chain: difference bit and borrow generate for a - bin.
module cbd_borrow_cell (
    input  logic a,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ bin;
    assign bout = ~a & bin;

endmodule

// File: rtl/cbd_down_counter.sv
// Cascadable down counter with clear, preset, load and sticky underflow.
// Define CBD_AUTORELOAD_EN to wrap to a reload register (written by LD) instead of all ones.
module cbd_down_counter
    import cbd_pkg::*;
#(
    parameter int               WIDTH   = CBD_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             CLK,
    input  logic             CD,
    input  logic             PS,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    input  logic             CBI,
    output logic [WIDTH-1:0] Q,
    output logic             CBO,
    output logic             UF
);

    localparam cbd_word_t        ONES_FULL = cbd_ones(WIDTH);
    localparam logic [WIDTH-1:0] ALL_ONES  = ONES_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] q_r;
    logic             uf_r;
    logic [WIDTH-1:0] dec;
    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] wrap_val;
    logic             is_zero;
    logic             count;

    // Subtracting a constant 1 through the chain: the final borrow-out is set only when Q == 0.
    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        cbd_borrow_cell u_cell (
            .a    (q_r[i]),
            .bin  (borrow[i]),
            .diff (dec[i]),
            .bout (borrow[i+1])
        );
    end

    assign is_zero = borrow[WIDTH];
    assign count   = EN & CBI;

`ifdef CBD_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_r;

    always_ff @(posedge CLK or posedge CD) begin
        if (CD) begin
            reload_r <= ALL_ONES;
        end else if (LD) begin
            reload_r <= D;
        end
    end

    assign wrap_val = reload_r;
`else
    assign wrap_val = ALL_ONES;
`endif

    always_ff @(posedge CLK or posedge CD) begin
        if (CD) begin
            q_r  <= RST_VAL;
            uf_r <= 1'b0;
        end else if (PS) begin
            q_r  <= ALL_ONES;
            uf_r <= 1'b0;
        end else if (LD) begin
            q_r  <= D;
            uf_r <= 1'b0;
        end else if (count) begin
            if (is_zero) begin
                q_r  <= wrap_val;
                uf_r <= 1'b1;
            end else begin
                q_r  <= dec;
            end
        end
    end

    assign Q   = q_r;
    assign UF  = uf_r;
    assign CBO = count & is_zero;

endmodule

// File: tb/tb_cbd_down_counter.sv
// Directed self-checking bench for cbd_down_counter, including a two-stage cascade.
module tb_cbd_down_counter;

    logic       clk;
    logic       cd, ps, ld, en, cbi;
    logic [7:0] d;
    logic [7:0] q;
    logic       cbo, uf;
    logic       up_cd, up_ps, up_ld, up_en;
    logic [7:0] up_d;
    logic [7:0] up_q;
    logic       up_cbo, up_uf;

    int errors = 0;
    int checks = 0;

`ifdef CBD_AUTORELOAD_EN
    localparam logic [7:0]  WRAP_FROM_LOAD2 = 8'h02;
    localparam logic [7:0]  WRAP_FROM_LOAD0 = 8'h00;
    localparam logic [15:0] CASCADE_FINAL   = 16'h0001;
`else
    localparam logic [7:0]  WRAP_FROM_LOAD2 = 8'hFF;
    localparam logic [7:0]  WRAP_FROM_LOAD0 = 8'hFF;
    localparam logic [15:0] CASCADE_FINAL   = 16'hFFFF;
`endif

    cbd_down_counter #(.WIDTH(8), .RST_VAL(8'h00)) dut (
        .CLK (clk), .CD (cd), .PS (ps), .LD (ld), .D (d),
        .EN (en), .CBI (cbi), .Q (q), .CBO (cbo), .UF (uf)
    );

    cbd_down_counter #(.WIDTH(8), .RST_VAL(8'h00)) dut_upper (
        .CLK (clk), .CD (up_cd), .PS (up_ps), .LD (up_ld), .D (up_d),
        .EN (up_en), .CBI (cbo), .Q (up_q), .CBO (up_cbo), .UF (up_uf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cd = 1'b1; ps = 1'b0; ld = 1'b0; d = 8'h00; en = 1'b0; cbi = 1'b1;
        up_cd = 1'b1; up_ps = 1'b0; up_ld = 1'b0; up_d = 8'h00; up_en = 1'b0;
        #2;
        checks++;
        if (q !== 8'h00) begin errors++; $display("[TB] FAIL reset_q: got %h expected 00", q); end
        checks++;
        if (uf !== 1'b0) begin errors++; $display("[TB] FAIL reset_uf: got %b expected 0", uf); end
        checks++;
        if (cbo !== 1'b0) begin errors++; $display("[TB] FAIL reset_cbo_idle: got %b expected 0", cbo); end
        en = 1'b1;
        #1;
        checks++;
        if (cbo !== 1'b1) begin errors++; $display("[TB] FAIL reset_cbo_zero: got %b expected 1", cbo); end
        en = 1'b0;
        cd = 1'b0; up_cd = 1'b0;
        tick();
        checks++;
        if (q !== 8'h00) begin errors++; $display("[TB] FAIL reset_release_q: got %h expected 00", q); end
    endtask

    task automatic test_async_clear();
        ld = 1'b1; d = 8'h5B;
        tick();
        ld = 1'b0; en = 1'b1; cbi = 1'b1;
        tick();
        checks++;
        if (q !== 8'h5A) begin errors++; $display("[TB] FAIL clear_precount: got %h expected 5a", q); end
        cd = 1'b1;
        #1;
        checks++;
        if (q !== 8'h00 || uf !== 1'b0) begin
            errors++; $display("[TB] FAIL clear_async: got q=%h uf=%b expected q=00 uf=0", q, uf);
        end
        cd = 1'b0;
        #1;
        checks++;
        if (q !== 8'h00) begin errors++; $display("[TB] FAIL clear_release: got %h expected 00", q); end
        tick();
        checks++;
        if (q !== 8'hFF || uf !== 1'b1) begin
            errors++; $display("[TB] FAIL clear_first_edge: got q=%h uf=%b expected q=ff uf=1", q, uf);
        end
        en = 1'b0;
        cd = 1'b1;
        #1;
        checks++;
        if (uf !== 1'b0 || q !== 8'h00) begin
            errors++; $display("[TB] FAIL clear_uf: got q=%h uf=%b expected q=00 uf=0", q, uf);
        end
        cd = 1'b0;
    endtask

    task automatic test_priority();
        ld = 1'b1; d = 8'h33; ps = 1'b1; en = 1'b1; cbi = 1'b1;
        tick();
        checks++;
        if (q !== 8'hFF || uf !== 1'b0) begin
            errors++; $display("[TB] FAIL prio_preset: got q=%h uf=%b expected q=ff uf=0", q, uf);
        end
        ps = 1'b0;
        tick();
        checks++;
        if (q !== 8'h33) begin errors++; $display("[TB] FAIL prio_load: got %h expected 33", q); end
        ld = 1'b0;
        tick();
        checks++;
        if (q !== 8'h32) begin errors++; $display("[TB] FAIL prio_count: got %h expected 32", q); end
        en = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_q   [3];
        logic       exp_uf  [3];
        logic       exp_cbo [3];
        exp_q   = '{8'h01, 8'h00, WRAP_FROM_LOAD2};
        exp_uf  = '{1'b0, 1'b0, 1'b1};
        exp_cbo = '{1'b0, 1'b1, 1'b0};
        ld = 1'b1; d = 8'h02;
        tick();
        ld = 1'b0; en = 1'b1; cbi = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q !== exp_q[i] || uf !== exp_uf[i] || cbo !== exp_cbo[i]) begin
                errors++;
                $display("[TB] FAIL wrap_step%0d: got q=%h uf=%b cbo=%b expected q=%h uf=%b cbo=%b",
                         i, q, uf, cbo, exp_q[i], exp_uf[i], exp_cbo[i]);
            end
        end
        en = 1'b0;
        ld = 1'b1; d = 8'h77;
        tick();
        checks++;
        if (q !== 8'h77 || uf !== 1'b0) begin
            errors++; $display("[TB] FAIL wrap_load_clears_uf: got q=%h uf=%b expected q=77 uf=0", q, uf);
        end
        ld = 1'b0;
    endtask

    task automatic test_hold();
        ld = 1'b1; d = 8'h00; en = 1'b0;
        tick();
        ld = 1'b0; en = 1'b1; cbi = 1'b1;
        tick();
        cbi = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q !== WRAP_FROM_LOAD0 || uf !== 1'b1 || cbo !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_cbi_low%0d: got q=%h uf=%b cbo=%b expected q=%h uf=1 cbo=0",
                         i, q, uf, cbo, WRAP_FROM_LOAD0);
            end
        end
        cbi = 1'b1; en = 1'b0;
        ld = 1'b1; d = 8'h40;
        tick();
        ld = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (q !== 8'h40 || cbo !== 1'b0 || uf !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_en_low%0d: got q=%h uf=%b cbo=%b expected q=40 uf=0 cbo=0",
                         i, q, uf, cbo);
            end
        end
    endtask

    task automatic test_cascade();
        ld = 1'b1; d = 8'h01; en = 1'b0; cbi = 1'b1;
        up_ld = 1'b1; up_d = 8'h00; up_en = 1'b0;
        tick();
        ld = 1'b0; up_ld = 1'b0; en = 1'b1; up_en = 1'b1;
        tick();
        checks++;
        if ({up_q, q} !== 16'h0000 || cbo !== 1'b1) begin
            errors++; $display("[TB] FAIL cascade_edge1: got %h cbo=%b expected 0000 cbo=1", {up_q, q}, cbo);
        end
        tick();
        checks++;
        if ({up_q, q} !== CASCADE_FINAL || up_uf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cascade_edge2: got %h up_uf=%b expected %h up_uf=1", {up_q, q}, up_uf, CASCADE_FINAL);
        end
        en = 1'b0; up_en = 1'b0;
    endtask

`ifdef CBD_AUTORELOAD_EN
    task automatic test_autoreload();
        logic [7:0] exp_q [4];
        exp_q = '{8'h02, 8'h01, 8'h00, 8'h03};
        ld = 1'b1; d = 8'h03; en = 1'b0; cbi = 1'b1;
        tick();
        ld = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (q !== exp_q[i]) begin
                errors++; $display("[TB] FAIL reload_step%0d: got %h expected %h", i, q, exp_q[i]);
            end
        end
        checks++;
        if (uf !== 1'b1) begin errors++; $display("[TB] FAIL reload_uf: got %b expected 1", uf); end
        ps = 1'b1;
        tick();
        ps = 1'b0;
        checks++;
        if (q !== 8'hFF || uf !== 1'b0) begin
            errors++; $display("[TB] FAIL reload_preset: got q=%h uf=%b expected q=ff uf=0", q, uf);
        end
        repeat (255) tick();
        checks++;
        if (q !== 8'h00) begin errors++; $display("[TB] FAIL reload_reach_zero: got %h expected 00", q); end
        tick();
        checks++;
        if (q !== 8'h03 || uf !== 1'b1) begin
            errors++; $display("[TB] FAIL reload_after_preset: got q=%h uf=%b expected q=03 uf=1", q, uf);
        end
        en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_async_clear();
        test_priority();
        test_wrap();
        test_hold();
        test_cascade();
`ifdef CBD_AUTORELOAD_EN
        test_autoreload();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
